// File: rtl/bunch_orbit_counter_reg.sv
// bunch_orbit_counter_reg
// Register stage for the two-level bunch (LSB) / orbit (MSB) counter.
// It holds the current counter state, which feeds the combinational
// next-count stage. Each enabled cycle it captures that stage's results.
// On top of that it adds clear/preset control, wrap pulses, error
// accounting and a four-phase snapshot port for slow control.
//
// Ports
//   clk_i, rst_n_i                clock, asynchronous active-low reset
//   cnt_en_i                      advance one step per cycle
//   sync_clr_i                    synchronous clear (highest priority)
//   preset_valid_i/_lsb_i/_msb_i  load preset values
//   next_lsb_cnt_i/next_msb_cnt_i results from the next-count stage
//   lsb_cnt_err_i                 LSB out-of-range flag from the next-count stage
//   lsb_cnt_o/msb_cnt_o           current counter state
//   lsb_wrap_o/msb_wrap_o         one-cycle wrap pulses
//   err_sticky_o/err_cnt_o        sticky error flag, saturating error count
//   err_clr_i                     clears the error flag and error count
//   snap_req_i/snap_ack_o         four-phase snapshot handshake
//   snap_lsb_o/snap_msb_o         captured counter values
module bunch_orbit_counter_reg #(
  parameter int LSB_W       = 12,
  parameter int MSB_W       = 3,
  parameter int LSB_CNT_MAX = 3563,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cnt_en_i,
  input  logic                 sync_clr_i,
  input  logic                 preset_valid_i,
  input  logic [LSB_W-1:0]     preset_lsb_i,
  input  logic [MSB_W-1:0]     preset_msb_i,
  input  logic [LSB_W-1:0]     next_lsb_cnt_i,
  input  logic [MSB_W-1:0]     next_msb_cnt_i,
  input  logic                 lsb_cnt_err_i,
  output logic [LSB_W-1:0]     lsb_cnt_o,
  output logic [MSB_W-1:0]     msb_cnt_o,
  output logic                 lsb_wrap_o,
  output logic                 msb_wrap_o,
  output logic                 err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 err_clr_i,
  input  logic                 snap_req_i,
  output logic                 snap_ack_o,
  output logic [LSB_W-1:0]     snap_lsb_o,
  output logic [MSB_W-1:0]     snap_msb_o
);

  localparam logic [LSB_W-1:0]     LSB_MAX_C = LSB_W'(LSB_CNT_MAX);
  localparam logic [MSB_W-1:0]     MSB_MAX_C = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX_C = '1;

  typedef enum logic {S_IDLE, S_ACK} snap_state_t;

  logic [LSB_W-1:0]     r_lsb;
  logic [MSB_W-1:0]     r_msb;
  logic                 r_lsb_wrap;
  logic                 r_msb_wrap;
  logic                 r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [LSB_W-1:0]     r_snap_lsb;
  logic [MSB_W-1:0]     r_snap_msb;
  snap_state_t          r_state;
  snap_state_t          w_state_nxt;
  logic                 w_snap_cap;

  // Clear beats preset, and preset beats enable. Only an unshadowed
  // enable is a real step.
  logic w_preset;
  logic w_step;
  logic w_err_evt;
  logic w_adv;

  assign w_preset  = preset_valid_i & ~sync_clr_i;
  assign w_step    = cnt_en_i & ~sync_clr_i & ~preset_valid_i;
  assign w_err_evt = w_step & lsb_cnt_err_i;
  // An erroring step holds the counter, so an out-of-range preset stays frozen.
  assign w_adv     = w_step & ~lsb_cnt_err_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lsb      <= '0;
      r_msb      <= '0;
      r_lsb_wrap <= 1'b0;
      r_msb_wrap <= 1'b0;
    end else begin
      if (sync_clr_i) begin
        r_lsb <= '0;
        r_msb <= '0;
      end else if (w_preset) begin
        r_lsb <= preset_lsb_i;
        r_msb <= preset_msb_i;
      end else if (w_adv) begin
        r_lsb <= next_lsb_cnt_i;
        r_msb <= next_msb_cnt_i;
      end
      // Wraps are decided from the pre-step state: MAX -> 0 on this edge.
      r_lsb_wrap <= w_adv & (r_lsb == LSB_MAX_C);
      r_msb_wrap <= w_adv & (r_lsb == LSB_MAX_C) & (r_msb == MSB_MAX_C);
    end
  end

  // The error event wins over a same-cycle clear, so a fresh error is
  // never lost: the result is sticky=1, count=1.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else if (err_clr_i) begin
      r_err_sticky <= w_err_evt;
      r_err_cnt    <= w_err_evt ? ERR_CNT_W'(1) : '0;
    end else if (w_err_evt) begin
      r_err_sticky <= 1'b1;
      if (r_err_cnt != ERR_MAX_C) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_snap_lsb <= '0;
      r_snap_msb <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_snap_cap) begin
        r_snap_lsb <= r_lsb;
        r_snap_msb <= r_msb;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_snap_cap  = 1'b0;
    case (r_state)
      S_IDLE: if (snap_req_i) begin
        w_snap_cap  = 1'b1;
        w_state_nxt = S_ACK;
      end
      S_ACK: if (!snap_req_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign lsb_cnt_o    = r_lsb;
  assign msb_cnt_o    = r_msb;
  assign lsb_wrap_o   = r_lsb_wrap;
  assign msb_wrap_o   = r_msb_wrap;
  assign err_sticky_o = r_err_sticky;
  assign err_cnt_o    = r_err_cnt;
  assign snap_ack_o   = (r_state == S_ACK);
  assign snap_lsb_o   = r_snap_lsb;
  assign snap_msb_o   = r_snap_msb;

endmodule

// File: tb/tb_bunch_orbit_counter_reg.sv
// Directed bench for bunch_orbit_counter_reg with a behavioural
// next-count stage attached.
module tb_bunch_orbit_counter_reg;

  localparam int MAXV = 3563;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_en = 1'b0, sync_clr = 1'b0, preset_valid = 1'b0;
  logic [11:0] preset_lsb = '0;
  logic [2:0]  preset_msb = '0;
  logic [11:0] next_lsb;
  logic [2:0]  next_msb;
  logic        lsb_err;
  logic [11:0] lsb_cnt;
  logic [2:0]  msb_cnt;
  logic        lsb_wrap, msb_wrap, err_sticky;
  logic [7:0]  err_cnt;
  logic        err_clr = 1'b0, snap_req = 1'b0, snap_ack;
  logic [11:0] snap_lsb;
  logic [2:0]  snap_msb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Next-count stage model: increment with wrap at MAXV, flag out-of-range.
  assign lsb_err  = (lsb_cnt > 12'(MAXV));
  assign next_lsb = lsb_err ? lsb_cnt : ((lsb_cnt == 12'(MAXV)) ? 12'd0 : lsb_cnt + 12'd1);
  assign next_msb = (lsb_cnt == 12'(MAXV)) ? msb_cnt + 3'd1 : msb_cnt;

  bunch_orbit_counter_reg dut (
    .clk_i(clk), .rst_n_i(rst_n), .cnt_en_i(cnt_en), .sync_clr_i(sync_clr),
    .preset_valid_i(preset_valid), .preset_lsb_i(preset_lsb), .preset_msb_i(preset_msb),
    .next_lsb_cnt_i(next_lsb), .next_msb_cnt_i(next_msb), .lsb_cnt_err_i(lsb_err),
    .lsb_cnt_o(lsb_cnt), .msb_cnt_o(msb_cnt), .lsb_wrap_o(lsb_wrap), .msb_wrap_o(msb_wrap),
    .err_sticky_o(err_sticky), .err_cnt_o(err_cnt), .err_clr_i(err_clr),
    .snap_req_i(snap_req), .snap_ack_o(snap_ack), .snap_lsb_o(snap_lsb), .snap_msb_o(snap_msb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_lsb"}, 32'(lsb_cnt), 0);
    check({tag, "_msb"}, 32'(msb_cnt), 0);
    check({tag, "_flags"}, {28'd0, lsb_wrap, msb_wrap, err_sticky, snap_ack}, 0);
    check({tag, "_errcnt"}, 32'(err_cnt), 0);
    check({tag, "_snap"}, {17'd0, snap_msb, snap_lsb}, 0);
  endtask

  initial begin
    int bad;
    int wraps;
    int mwraps;
    int snap2;

    // Reset state.
    #12;
    all_zero("reset");
    rst_n = 1'b1;
    step();

    // Full orbit: 3564 enabled steps.
    cnt_en = 1'b1;
    bad = 0; wraps = 0; mwraps = 0;
    for (int k = 1; k <= 3564; k++) begin
      step();
      if (lsb_cnt !== ((k == 3564) ? 12'd0 : 12'(k))) bad++;
      if (msb_cnt !== ((k == 3564) ? 3'd1 : 3'd0)) bad++;
      if (lsb_wrap !== (k == 3564)) bad++;
      wraps += int'(lsb_wrap);
      mwraps += int'(msb_wrap);
    end
    check("orbit_seq_mismatches", bad, 0);
    check("orbit_lsb_end", 32'(lsb_cnt), 0);
    check("orbit_msb_end", 32'(msb_cnt), 1);
    check("orbit_lsb_wraps", wraps, 1);
    check("orbit_msb_wraps", mwraps, 0);
    cnt_en = 1'b0;
    step();
    check("hold_lsb", 32'(lsb_cnt), 0);
    check("wrap_pulse_len", 32'(lsb_wrap), 0);

    // Double wrap from MAX/7.
    preset_valid = 1'b1; preset_lsb = 12'd3563; preset_msb = 3'd7;
    step();
    preset_valid = 1'b0;
    check("preset_lsb", 32'(lsb_cnt), 3563);
    check("preset_msb", 32'(msb_cnt), 7);
    check("preset_nowrap", {lsb_wrap, msb_wrap}, 0);
    cnt_en = 1'b1;
    step();
    cnt_en = 1'b0;
    check("dwrap_cnt", {msb_cnt, lsb_cnt}, 0);
    check("dwrap_pulses", {lsb_wrap, msb_wrap}, 2'b11);
    step();
    check("dwrap_pulse_end", {lsb_wrap, msb_wrap}, 0);

    // Out-of-range preset and error accounting.
    preset_valid = 1'b1; preset_lsb = 12'd4000; preset_msb = 3'd2;
    step();
    preset_valid = 1'b0;
    check("oor_no_err_on_preset", {err_sticky, err_cnt}, 0);
    cnt_en = 1'b1;
    step();
    check("oor_err1", {err_sticky, err_cnt}, {1'b1, 8'd1});
    repeat (4) step();
    check("oor_lsb_frozen", 32'(lsb_cnt), 4000);
    check("oor_msb_frozen", 32'(msb_cnt), 2);
    check("oor_err5", {err_sticky, err_cnt}, {1'b1, 8'd5});
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_with_err", {err_sticky, err_cnt}, {1'b1, 8'd1});
    repeat (300) step();
    check("err_saturate", 32'(err_cnt), 255);
    cnt_en = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clear_only", {err_sticky, err_cnt}, 0);

    // Clear beats preset beats enable.
    preset_valid = 1'b1; preset_lsb = 12'd100; preset_msb = 3'd3;
    step();
    sync_clr = 1'b1; preset_lsb = 12'd200; cnt_en = 1'b1;
    step();
    check("prio_clr", {msb_cnt, lsb_cnt}, 0);
    check("prio_clr_nowrap", {lsb_wrap, msb_wrap}, 0);
    sync_clr = 1'b0; preset_lsb = 12'd3563; preset_msb = 3'd7;
    step();
    preset_lsb = 12'd5; preset_msb = 3'd1;
    step();
    check("prio_preset_over_en", {msb_cnt, lsb_cnt}, {3'd1, 12'd5});
    check("prio_preset_nowrap", {lsb_wrap, msb_wrap}, 0);
    preset_valid = 1'b0; cnt_en = 1'b0;

    // Snapshot handshake.
    preset_valid = 1'b1; preset_lsb = 12'd40; preset_msb = 3'd4;
    step();
    preset_valid = 1'b0; cnt_en = 1'b1;
    step();
    step();
    check("snap_pre_lsb", 32'(lsb_cnt), 42);
    check("snap_pre_ack", 32'(snap_ack), 0);
    snap_req = 1'b1;
    step();
    check("snap_ack1", 32'(snap_ack), 1);
    check("snap_val", {snap_msb, snap_lsb}, {3'd4, 12'd42});
    repeat (3) step();
    check("snap_frozen", {snap_msb, snap_lsb}, {3'd4, 12'd42});
    check("snap_ack_hold", 32'(snap_ack), 1);
    snap_req = 1'b0;
    step();
    check("snap_ack_drop", 32'(snap_ack), 0);
    check("snap_kept", 32'(snap_lsb), 42);
    snap2 = int'(lsb_cnt);
    snap_req = 1'b1;
    step();
    check("snap2_ack", 32'(snap_ack), 1);
    check("snap2_val", 32'(snap_lsb), snap2);

    // Asynchronous reset mid-count with ack high.
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("async_rst");
    snap_req = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_lsb", 32'(lsb_cnt), 1);
    check("post_rst_ack", 32'(snap_ack), 0);
    step();
    snap2 = int'(lsb_cnt);
    snap_req = 1'b1;
    step();
    check("post_rst_snap_ack", 32'(snap_ack), 1);
    check("post_rst_snap_val", 32'(snap_lsb), snap2);
    snap_req = 1'b0; cnt_en = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bunch_orbit_counter_reg.md
Name: bunch_orbit_counter_reg

Overview:
- Register stage for the two-level bunch/orbit counter.
- Holds the 12-bit LSB (bunch) and 3-bit MSB (orbit) state and feeds it to the combinational next-count stage.
- Captures that stage's next_lsb/next_msb/error results each enabled cycle.
- Adds clear/preset control, wrap pulses, error accounting and a four-phase snapshot readout port for slow control.

Parameters:
- LSB_W, 12, LSB counter width.
- MSB_W, 3, MSB counter width.
- LSB_CNT_MAX, 3563, last valid LSB value; must match the package constant used by the next-count stage.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- cnt_en_i  in  1  advance enable, one step per cycle.
- sync_clr_i  in  1  synchronous counter clear.
- preset_valid_i  in  1  load preset values.
- preset_lsb_i  in  LSB_W  preset LSB value.
- preset_msb_i  in  MSB_W  preset MSB value.
- next_lsb_cnt_i  in  LSB_W  next LSB from the next-count stage.
- next_msb_cnt_i  in  MSB_W  next MSB from the next-count stage.
- lsb_cnt_err_i  in  1  LSB out-of-range flag from the next-count stage.
- lsb_cnt_o  out  LSB_W  current LSB; drives next-count stage lsb_cnt_i.
- msb_cnt_o  out  MSB_W  current MSB; drives next-count stage msb_cnt_i.
- lsb_wrap_o  out  1  one-cycle pulse, LSB wrapped MAX->0.
- msb_wrap_o  out  1  one-cycle pulse, MSB wrapped all-ones->0.
- err_sticky_o  out  1  sticky out-of-range flag.
- err_cnt_o  out  ERR_CNT_W  saturating count of enabled error cycles.
- err_clr_i  in  1  clears err_sticky_o and err_cnt_o.
- snap_req_i  in  1  snapshot request (four-phase).
- snap_ack_o  out  1  snapshot acknowledge.
- snap_lsb_o  out  LSB_W  captured LSB.
- snap_msb_o  out  MSB_W  captured MSB.

Behaviour:
- One clock; reset is asynchronous and active-low (clk_i, rst_n_i). All flops are reset by rst_n_i only.
- Reset values: every output is 0. Snapshot FSM is in IDLE.
- Counter update priority per cycle, highest first:
  - sync_clr_i: lsb=0, msb=0.
  - preset_valid_i: lsb=preset_lsb_i, msb=preset_msb_i.
  - cnt_en_i: lsb=next_lsb_cnt_i, msb=next_msb_cnt_i.
  - Otherwise: hold.
- Latency: lsb_cnt_o/msb_cnt_o change one cycle after the controlling input is sampled.
- Wrap pulses:
  - lsb_wrap_o=1 in the cycle after an enabled step with lsb_cnt_o==LSB_CNT_MAX, lsb_cnt_err_i=0, and no clear or preset.
  - msb_wrap_o=1 in the same cycle if msb_cnt_o was all-ones at that step.
  - Both pulses are suppressed when clear or preset wins.
- Error accounting:
  - An error event is cnt_en_i=1, lsb_cnt_err_i=1, with no clear or preset active.
  - On an error event the counter holds its value.
  - err_sticky_o is set one cycle later.
  - err_cnt_o increments by 1 and saturates at all-ones; no wrap.
- err_clr_i:
  - Zeroes err_sticky_o and err_cnt_o.
  - On a same-cycle err_clr_i and error event: err_sticky_o=1, err_cnt_o=1.
- Out-of-range state:
  - A preset above LSB_CNT_MAX is accepted as given.
  - The counter then stays frozen on every enabled cycle, counting errors, until sync_clr_i or a valid preset.
- Snapshot FSM, states IDLE and ACK:
  - IDLE & snap_req_i=1: capture the current lsb_cnt_o/msb_cnt_o (the pre-update values of that cycle) into snap_*_o, go to ACK. snap_ack_o=1 from the next cycle.
  - ACK: snap_*_o are frozen; snap_ack_o stays 1 while snap_req_i=1.
  - ACK & snap_req_i=0: go to IDLE, snap_ack_o=0 next cycle. snap_*_o keep their last values.
  - A new capture is possible only after ack has dropped.
- Widths: all counter paths are exact LSB_W/MSB_W. No arithmetic is done here; incrementing belongs to the next-count stage.
- Reset mid-operation: immediately zeroes counters, flags and snapshot; FSM returns to IDLE.

Test Plan:
- Reset, then cnt_en_i=1 for 3564 cycles with the next-count stage attached -> lsb steps 0..3563 then 0, msb 0->1, one lsb_wrap_o pulse, msb_wrap_o=0.
- Preset lsb=3563 msb=7, then one enabled step -> lsb=0, msb=0, lsb_wrap_o and msb_wrap_o both pulse for one cycle.
- Preset lsb=4000, 5 enabled cycles -> lsb stays 4000, err_sticky_o=1, err_cnt_o=5. Then err_clr_i plus an error in the same cycle -> err_cnt_o=1. Then 300 error cycles -> err_cnt_o=255.
- sync_clr_i, preset_valid_i and cnt_en_i all high with the counter at 100 -> lsb=0, msb=0, no wrap pulse.
- snap_req_i raised while counting at lsb=42 -> snap_lsb_o=42 and ack one cycle later; snap_lsb_o unchanged while the counter advances. Drop req -> ack low next cycle; re-raise -> new capture.
- rst_n_i asserted mid-count with ack high -> all outputs 0 asynchronously; after release counting restarts from 0 and the FSM is in IDLE.
